// File: rtl/color_pkg.sv
// Shared pixel types for the color gather/serializer path.
package color_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } t_color;

    localparam int DN_MAX = 16;

    typedef enum logic {
        GATHER_FILL = 1'b0,
        GATHER_HOLD = 1'b1
    } t_gather_state;

endpackage

// File: rtl/color_gather.sv
// Gathers up to DN pixels into one group; in_last closes a group early.
// Optional macro COLOR_GATHER_CNT_EN adds a 32-bit output-group counter (grp_cnt).
//
// state | meaning
// FILL  | collecting pixels into storage, in_rdy=1, out_vld=0
// HOLD  | group presented on out_color/out_cnt until consumer takes it
module color_gather
    import color_pkg::*;
#(
    parameter int DN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  t_color                   in_color,
    input  logic                     in_last,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output t_color                   out_color [DN-1:0],
    output logic [$clog2(DN+1)-1:0]  out_cnt
`ifdef COLOR_GATHER_CNT_EN
    ,
    output logic [31:0]              grp_cnt
`endif
);

    localparam int IW = (DN > 1) ? $clog2(DN) : 1;
    localparam int CW = $clog2(DN + 1);

    t_gather_state   state_q;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   cnt_q;
    t_color          data_q [DN];

    logic            in_acc;
    logic            out_hs;
    logic            closing;

    // In HOLD the slot for the next group frees exactly when the consumer takes the current one.
    assign in_rdy  = !rst && ((state_q == GATHER_FILL) || out_rdy);
    assign out_vld = (state_q == GATHER_HOLD);
    assign out_cnt = cnt_q;

    assign in_acc  = in_vld && in_rdy;
    assign out_hs  = out_vld && out_rdy;
    assign closing = in_acc && (in_last || (idx_q == IW'(DN - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= GATHER_FILL;
            idx_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DN; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            if (in_acc) begin
                data_q[idx_q] <= in_color;
            end
            if (closing) begin
                state_q <= GATHER_HOLD;
                cnt_q   <= CW'(idx_q) + CW'(1);
                idx_q   <= '0;
            end else begin
                if (in_acc) begin
                    idx_q <= idx_q + IW'(1);
                end
                if (out_hs) begin
                    state_q <= GATHER_FILL;
                    cnt_q   <= '0;
                end
            end
        end
    end

    // Stale entries from a longer previous group are hidden behind out_cnt.
    always_comb begin
        for (int i = 0; i < DN; i++) begin
            out_color[i] = (CW'(i) < cnt_q) ? data_q[i] : '0;
        end
    end

`ifdef COLOR_GATHER_CNT_EN
    logic [31:0] grp_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_cnt_q <= '0;
        end else if (out_hs) begin
            grp_cnt_q <= grp_cnt_q + 32'd1;
        end
    end

    assign grp_cnt = grp_cnt_q;
`endif

endmodule

// File: tb/tb_color_gather.sv
// Directed bench for color_gather (DN=4) with a queue-based reference model checked every cycle.
module tb_color_gather;
    import color_pkg::*;

    localparam int DN = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_vld;
    logic         in_rdy;
    t_color       in_color;
    logic         in_last;
    logic         out_vld;
    logic         out_rdy;
    t_color       out_color [DN-1:0];
    logic [2:0]   out_cnt;
`ifdef COLOR_GATHER_CNT_EN
    logic [31:0]  grp_cnt;
`endif

    color_gather #(.DN(DN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_color  (in_color),
        .in_last   (in_last),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_color (out_color),
        .out_cnt   (out_cnt)
`ifdef COLOR_GATHER_CNT_EN
        ,
        .grp_cnt   (grp_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    logic [31:0] mdl_grp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        t_color px [DN];
        int     n;
    } grp_t;

    t_color cur [$];
    grp_t   pend [$];

    // Reference model: pixels accumulate in a list; a full list or in_last makes a pending group.
    always @(negedge clk) begin
        logic exp_rdy;
        grp_t g;
        if (rst) begin
            check("rst_in_rdy", 32'(in_rdy), 32'd0);
            check("rst_out_vld", 32'(out_vld), 32'd0);
            check("rst_out_cnt", 32'(out_cnt), 32'd0);
            for (int i = 0; i < DN; i++) check("rst_out_color", 32'(out_color[i]), 32'd0);
            cur.delete();
            pend.delete();
            mdl_grp = '0;
        end else begin
            exp_rdy = (pend.size() == 0) || out_rdy;
            check("in_rdy", 32'(in_rdy), 32'(exp_rdy));
            check("out_vld", 32'(out_vld), 32'(pend.size() != 0));
            if (pend.size() != 0) begin
                check("out_cnt", 32'(out_cnt), 32'(pend[0].n));
                for (int i = 0; i < DN; i++)
                    check("out_color", 32'(out_color[i]), (i < pend[0].n) ? 32'(pend[0].px[i]) : 32'd0);
            end
`ifdef COLOR_GATHER_CNT_EN
            check("grp_cnt", grp_cnt, mdl_grp);
`endif
            if (in_vld && !in_rdy) stalls++;
            if (pend.size() != 0 && out_rdy) begin
                void'(pend.pop_front());
                mdl_grp = mdl_grp + 32'd1;
            end
            if (in_vld && exp_rdy) begin
                cur.push_back(in_color);
                if (cur.size() == DN || in_last) begin
                    for (int i = 0; i < DN; i++) g.px[i] = (i < cur.size()) ? cur[i] : '0;
                    g.n = cur.size();
                    pend.push_back(g);
                    cur.delete();
                end
            end
        end
    end

    task automatic push(input logic [23:0] c, input logic l);
        int   n;
        logic ok;
        n = 0;
        in_vld   = 1'b1;
        in_color = c;
        in_last  = l;
        do begin
            @(negedge clk);
            ok = in_rdy;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) check("push_timeout", 32'd0, 32'd1);
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_vld   = 1'b0;
        in_color = '0;
        in_last  = 1'b0;
        out_rdy  = 1'b1;
        repeat (2) @(negedge clk);
        check("lit_rst_in_rdy", 32'(in_rdy), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("lit_rdy_after_rst", 32'(in_rdy), 32'd1);
        step();

        // full group
        for (int i = 0; i < 4; i++) push({3{8'(i)}}, 1'b0);
        check("full_vld", 32'(out_vld), 32'd1);
        check("full_cnt", 32'(out_cnt), 32'd4);
        check("full_c3", 32'(out_color[3]), 32'h030303);
        step();
        check("full_vld_one_cycle", 32'(out_vld), 32'd0);

        // early last
        push(24'h0A0A0A, 1'b0);
        push(24'h0B0B0B, 1'b1);
        check("early_cnt", 32'(out_cnt), 32'd2);
        check("early_c1", 32'(out_color[1]), 32'h0B0B0B);
        check("early_c2", 32'(out_color[2]), 32'd0);
        check("early_c3", 32'(out_color[3]), 32'd0);
        step();

        // backpressure with next pixel waiting
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) push({3{8'(8'h10 + i)}}, 1'b0);
        in_vld   = 1'b1;
        in_color = 24'h141414;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_rdy", 32'(in_rdy), 32'd0);
            check("bp_c0_stable", 32'(out_color[0]), 32'h101010);
            check("bp_c3_stable", 32'(out_color[3]), 32'h131313);
            step();
        end
        out_rdy = 1'b1;
        @(negedge clk);
        check("bp_release_rdy", 32'(in_rdy), 32'd1);
        step();
        in_vld = 1'b0;
        check("bp_after_hs_vld", 32'(out_vld), 32'd0);
        for (int i = 5; i < 8; i++) push({3{8'(8'h10 + i)}}, 1'b0);
        check("bp_next_c0", 32'(out_color[0]), 32'h141414);
        check("bp_next_c3", 32'(out_color[3]), 32'h171717);

        // streaming, starting while previous group is still held
        stalls = 0;
        for (int i = 0; i < 16; i++) push({3{8'(i)}}, 1'b0);
        check("stream_stalls", 32'(stalls), 32'd0);
        check("stream_last_c0", 32'(out_color[0]), 32'h0C0C0C);
        check("stream_last_c3", 32'(out_color[3]), 32'h0F0F0F);
        step();
`ifdef COLOR_GATHER_CNT_EN
        check("lit_grp_cnt", grp_cnt, 32'd8);
`endif

        // in_last on first and on final pixel
        push(24'h505050, 1'b1);
        check("last_first_cnt", 32'(out_cnt), 32'd1);
        check("last_first_c1", 32'(out_color[1]), 32'd0);
        step();
        for (int i = 0; i < 4; i++) push({3{8'(8'h40 + i)}}, i == 3);
        check("last_full_cnt", 32'(out_cnt), 32'd4);
        step();

        // reset mid-group
        push(24'h303030, 1'b0);
        push(24'h313131, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        repeat (3) begin
            step();
            check("rst_mid_no_vld", 32'(out_vld), 32'd0);
        end
        for (int i = 0; i < 4; i++) push({3{8'(8'h20 + i)}}, 1'b0);
        check("rst_mid_cnt", 32'(out_cnt), 32'd4);
        check("rst_mid_c0", 32'(out_color[0]), 32'h202020);
        check("rst_mid_c3", 32'(out_color[3]), 32'h232323);
        step();

`ifdef COLOR_GATHER_CNT_EN
        dut.grp_cnt_q = 32'hFFFF_FFFF;
        mdl_grp       = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) push({3{8'(8'h60 + i)}}, 1'b0);
        step();
        check("lit_grp_wrap", grp_cnt, 32'd0);
`endif

        repeat (3) step();
        check("model_drained", 32'(pend.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
